tri_strip_sequencer: RTL and testbench

- Responder for the `draw_tri_pipe_start` / `draw_tri_pipe_done` handshake issued by the mesh controller.
- On a start pulse it walks the MVP result memory, assembles vertex triples (strip or list), and issues one `draw_en` per triangle to the triangle rasteriser, waiting for `draw_done` between triangles.
- It reports completion by re-asserting `done`.

---
 rtl/tri_strip_sequencer.sv | 165 ++++++++++++++++
 tb/tb_tri_strip_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tri_strip_sequencer.sv
// Walks the MVP result memory, assembles strip/list vertex triples and hands each triangle to the rasteriser.
// Optional back-face/degenerate culling stage enabled by defining TRI_CULL_EN.
module tri_strip_sequencer #(
    parameter int WIDTH        = 32,
    parameter int COLOUR_WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic                    strip,
    input  logic [WIDTH-1:0]        count,
    output logic                    done,
    output logic [WIDTH-1:0]        mem_read_addr,
    input  logic [31:0]             mem_read_data,
    output logic [WIDTH-1:0]        mem_col_addr,
    input  logic [COLOUR_WIDTH-1:0] mem_col_data,
    output logic [15:0]             ax,
    output logic [15:0]             ay,
    output logic [15:0]             bx,
    output logic [15:0]             by,
    output logic [15:0]             cx,
    output logic [15:0]             cy,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    draw_en,
    input  logic                    draw_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef TRI_CULL_EN
        S_CULL,
`endif
        S_DRAW,
        S_WAIT_DRAW,
        S_NEXT
    } state_t;

    state_t                  r_state, w_next;
    logic [WIDTH-1:0]        r_vidx, r_tidx, r_cnt;
    logic [1:0]              r_need;
    logic                    r_mode;
    logic [31:0]             r_a, r_b, r_c;
    logic [15:0]             r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
    logic [COLOUR_WIDTH-1:0] r_colour;
    logic [WIDTH-1:0]        r_rd_addr, r_col_addr;
    logic [WIDTH-1:0]        w_tidx_inc;
    logic                    w_last_tri;

    assign w_tidx_inc = r_tidx + 1'b1;
    assign w_last_tri = (w_tidx_inc == r_cnt);

`ifdef TRI_CULL_EN
    // Edge vectors widened to 34 bits so the products and difference keep their sign.
    logic signed [33:0] w_dx1, w_dy1, w_dx2, w_dy2, w_area, w_area_s;
    logic               w_cull;
    assign w_dx1    = $signed({18'd0, r_bx}) - $signed({18'd0, r_ax});
    assign w_dy1    = $signed({18'd0, r_by}) - $signed({18'd0, r_ay});
    assign w_dx2    = $signed({18'd0, r_cx}) - $signed({18'd0, r_ax});
    assign w_dy2    = $signed({18'd0, r_cy}) - $signed({18'd0, r_ay});
    assign w_area   = (w_dx1 * w_dy2) - (w_dy1 * w_dx2);
    // Odd strip triangles have reversed winding.
    assign w_area_s = (r_mode && r_tidx[0]) ? -w_area : w_area;
    assign w_cull   = (w_area_s <= 34'sd0);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start && count != '0) w_next = S_ADDR;
            S_ADDR:      w_next = S_DATA;
`ifdef TRI_CULL_EN
            S_DATA:      w_next = (r_need == 2'd1) ? S_CULL : S_ADDR;
            S_CULL:      w_next = w_cull ? S_NEXT : S_DRAW;
`else
            S_DATA:      w_next = (r_need == 2'd1) ? S_DRAW : S_ADDR;
`endif
            S_DRAW:      w_next = S_WAIT_DRAW;
            S_WAIT_DRAW: if (draw_done) w_next = S_NEXT;
            S_NEXT:      w_next = w_last_tri ? S_IDLE : S_ADDR;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Address registers are loaded on entry to S_ADDR so the RAM sees them for the whole S_ADDR cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_vidx     <= '0;
            r_tidx     <= '0;
            r_cnt      <= '0;
            r_need     <= 2'd0;
            r_mode     <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_ax       <= '0;
            r_ay       <= '0;
            r_bx       <= '0;
            r_by       <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_colour   <= '0;
            r_rd_addr  <= '0;
            r_col_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start && count != '0) begin
                    r_cnt      <= count;
                    r_mode     <= strip;
                    r_vidx     <= '0;
                    r_tidx     <= '0;
                    r_need     <= 2'd3;
                    r_rd_addr  <= '0;
                    r_col_addr <= '0;
                end
                S_DATA: begin
                    r_a    <= r_b;
                    r_b    <= r_c;
                    r_c    <= mem_read_data;
                    r_vidx <= r_vidx + 1'b1;
                    r_need <= r_need - 2'd1;
                    if (r_need == 2'd1) begin
                        r_colour <= mem_col_data;
                        r_ax     <= r_b[31:16];
                        r_ay     <= r_b[15:0];
                        r_bx     <= r_c[31:16];
                        r_by     <= r_c[15:0];
                        r_cx     <= mem_read_data[31:16];
                        r_cy     <= mem_read_data[15:0];
                    end else begin
                        r_rd_addr <= r_vidx + 1'b1;
                    end
                end
                S_NEXT: begin
                    r_tidx <= w_tidx_inc;
                    if (!w_last_tri) begin
                        r_need     <= r_mode ? 2'd1 : 2'd3;
                        r_rd_addr  <= r_vidx;
                        r_col_addr <= w_tidx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done          = (r_state == S_IDLE);
    assign draw_en       = (r_state == S_DRAW);
    assign mem_read_addr = r_rd_addr;
    assign mem_col_addr  = r_col_addr;
    assign ax            = r_ax;
    assign ay            = r_ay;
    assign bx            = r_bx;
    assign by            = r_by;
    assign cx            = r_cx;
    assign cy            = r_cy;
    assign colour        = r_colour;

endmodule

// File: tb/tb_tri_strip_sequencer.sv
// Scoreboard bench for tri_strip_sequencer: reference triangles queued per job, monitor pops on draw_en.
module tb_tri_strip_sequencer;
    localparam int W  = 32;
    localparam int CW = 3;

    typedef struct packed {
        logic [15:0]   ax, ay, bx, by, cx, cy;
        logic [CW-1:0] col;
    } tri_t;

    logic          clock = 1'b0, resetn = 1'b0, start = 1'b0, strip = 1'b0, draw_done = 1'b0;
    logic [W-1:0]  count = '0;
    logic          done, draw_en;
    logic [W-1:0]  mem_read_addr, mem_col_addr;
    logic [31:0]   mem_read_data;
    logic [CW-1:0] mem_col_data, colour;
    logic [15:0]   ax, ay, bx, by, cx, cy;

    tri_strip_sequencer #(.WIDTH(W), .COLOUR_WIDTH(CW)) dut (
        .clock(clock), .resetn(resetn), .start(start), .strip(strip), .count(count),
        .done(done), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .mem_col_addr(mem_col_addr), .mem_col_data(mem_col_data),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .colour(colour), .draw_en(draw_en), .draw_done(draw_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0]   vmem [0:255];
    logic [CW-1:0] cmem [0:255];
    always @(posedge clock) begin
        mem_read_data <= vmem[mem_read_addr[7:0]];
        mem_col_data  <= cmem[mem_col_addr[7:0]];
    end

    int   checks = 0, errors = 0;
    int   dd_delay = 3, last_dd = 0, exp_draw_cyc = 0, n_draws = 0;
    bit   cur_strip = 1'b0;
    tri_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Rasteriser stand-in: returns draw_done dd_delay cycles after each draw_en.
    always begin
        @(negedge clock);
        if (resetn && draw_en) begin
            repeat (dd_delay) @(negedge clock);
            draw_done    = 1'b1;
            last_dd      = cyc + 1;
            exp_draw_cyc = cyc + 1 + (cur_strip ? 3 : 7);
            @(negedge clock);
            draw_done = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (resetn && draw_en) begin
            tri_t got, e;
            n_draws++;
            got = {ax, ay, bx, by, cx, cy, colour};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected draw_en: got triangle %0h, expected none (cycle %0d)", got, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("triangle", got, e);
            end
`ifndef TRI_CULL_EN
            chk("draw timing", cyc, exp_draw_cyc);
`endif
        end
    end

    // Reference: triangle i takes vertices i..i+2 (strip) or 3i..3i+2 (list), colour index i.
    task automatic build(input bit s, input int n);
        for (int i = 0; i < n; i++) begin
            int          b;
            tri_t        t;
            logic [31:0] va, vb, vc;
            b  = s ? i : 3 * i;
            va = vmem[b % 256];
            vb = vmem[(b + 1) % 256];
            vc = vmem[(b + 2) % 256];
            t  = {va[31:16], va[15:0], vb[31:16], vb[15:0], vc[31:16], vc[15:0], cmem[i % 256]};
`ifdef TRI_CULL_EN
            begin
                longint      ar;
                logic [33:0] a34;
                ar = (longint'(t.bx) - longint'(t.ax)) * (longint'(t.cy) - longint'(t.ay))
                   - (longint'(t.by) - longint'(t.ay)) * (longint'(t.cx) - longint'(t.ax));
                if (s && (i % 2 == 1)) ar = -ar;
                a34 = ar[33:0];
                if ($signed(a34) > 0) exp_q.push_back(t);
            end
`else
            exp_q.push_back(t);
`endif
        end
    endtask

    // variant: 0 normal, 1 long draw with stray starts, 2 reset abort after first draw
    task automatic run_job(input bit s, input int n, input int delay, input int variant);
        int st, d0, exp_n, t;
        logic [W-1:0] saved;
        dd_delay  = delay;
        cur_strip = s;
        exp_q.delete();
        build(s, n);
        exp_n = exp_q.size();
        d0    = n_draws;
        saved = '0;
        @(negedge clock);
        start = 1'b1; strip = s; count = n;
        st = cyc + 1;
        exp_draw_cyc = st + 6;
        @(negedge clock);
        start = 1'b0; strip = 1'($urandom); count = $urandom;
        chk("done falls", done, 1'b0);
        if (variant == 2) begin
            t = 0;
            while (n_draws == d0 && t < 200) begin @(negedge clock); t++; end
            chk("first draw before abort", n_draws - d0, 1);
            repeat (5) @(negedge clock);
            #2 resetn = 1'b0;
            #1;
            chk("abort done", done, 1'b1);
            chk("abort draw_en", draw_en, 1'b0);
            chk("abort coords", {ax, ay, bx, by, cx, cy, colour}, '0);
            chk("abort addr", mem_read_addr, '0);
            exp_q.delete();
            @(negedge clock);
            resetn = 1'b1;
            repeat (30) @(negedge clock);
            return;
        end
        t = 0;
        while (!done && t < 3000) begin
            if (variant == 1) begin
                if (t == 10 || t == 20 || t == 30) begin
                    start = 1'b1; count = $urandom_range(1, 5); strip = 1'($urandom);
                end else start = 1'b0;
                if (t == 8)  saved = mem_read_addr;
                if (t == 40) begin
                    chk("stall addr held", mem_read_addr, saved);
                    chk("stall draws", n_draws - d0, 1);
                end
            end
            @(negedge clock);
            t++;
        end
        start = 1'b0;
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL job timeout: done still 0 after %0d cycles, expected 1", t);
        end
`ifndef TRI_CULL_EN
        chk("done timing", cyc, last_dd + 1);
`endif
        chk("draw count", n_draws - d0, exp_n);
        chk("last vertex addr", mem_read_addr, s ? n + 1 : 3 * n - 1);
        chk("last colour addr", mem_col_addr, n - 1);
        @(negedge clock);
    endtask

    initial begin
        int ok;
        logic [W-1:0] saved;
        for (int i = 0; i < 256; i++) begin
            vmem[i] = $urandom;
            cmem[i] = CW'($urandom_range(0, 7));
        end
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("reset done", done, 1'b1);
        chk("reset draw_en", draw_en, 1'b0);
        chk("reset addrs", {mem_read_addr, mem_col_addr}, '0);
        chk("reset coords", {ax, ay, bx, by, cx, cy, colour}, '0);

        vmem[0] = {16'd10, 16'd10}; vmem[1] = {16'd50, 16'd10};
        vmem[2] = {16'd10, 16'd50}; vmem[3] = {16'd50, 16'd50};
        run_job(1'b1, 2, 3, 0);

        cmem[0] = 3'd5; cmem[1] = 3'd2;
        run_job(1'b0, 2, 3, 0);

        saved = mem_read_addr;
        ok = n_draws;
        @(negedge clock);
        start = 1'b1; count = '0; strip = 1'b1;
        @(negedge clock);
        start = 1'b0;
        begin
            int stayed;
            stayed = 1;
            repeat (10) begin
                if (done !== 1'b1) stayed = 0;
                @(negedge clock);
            end
            chk("count0 done held", stayed, 1);
        end
        chk("count0 addr", mem_read_addr, saved);
        chk("count0 draws", n_draws - ok, 0);

        run_job(1'b1, 2, 50, 1);

        run_job(1'b1, 3, 20, 2);
        run_job(1'b1, 2, 3, 0);

        vmem[0] = {16'd0, 16'd0};  vmem[1] = {16'd10, 16'd0};
        vmem[2] = {16'd0, 16'd10}; vmem[3] = {16'd5, 16'd5};
        vmem[4] = {16'd10, 16'd10};
        run_job(1'b1, 3, 2, 0);

        repeat (12) begin
            for (int i = 0; i < 64; i++) begin
                vmem[i] = $urandom;
                cmem[i] = CW'($urandom_range(0, 7));
            end
            run_job(1'($urandom), $urandom_range(1, 8), $urandom_range(1, 5), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
